nav_arb: RTL and testbench

- Sequencing arbiter between the two move requesters (command processor, maze solver) and the single navigate unit.
- Captures each requester's start pulse into a one-deep pending slot and issues moves one at a time.
- Holds heading and stop controls stable for the whole move and routes move-complete back only to the requester that owns the move.
- Replaces the combinational cmd_md mux; adds watchdog timeout and a busy/owner status.

---
 rtl/nav_arb_pkg.sv | 27 ++
 rtl/nav_req_slot.sv | 31 +++
 rtl/nav_arb.sv | 154 +++++++++++++++
 tb/tb_nav_arb.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nav_arb_pkg.sv
// Shared types for the navigate-unit arbiter: FSM states, move owner and the
// pending-request record held by each requester slot.
package nav_arb_pkg;

   localparam int HDNG_W = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_CMD = 1'b0,
      OWN_SLV = 1'b1
   } owner_t;

   typedef struct packed {
      logic              vld;
      logic              is_mv;
      logic              stp_lft;
      logic              stp_rght;
      logic [HDNG_W-1:0] hdng;
   } req_t;

endpackage

// File: rtl/nav_req_slot.sv
// One-deep pending request buffer: a new pulse overwrites, clr discards,
// take consumes. Clear beats capture, capture beats take.
module nav_req_slot
   import nav_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              strt_hdng,
   input  logic              strt_mv,
   input  logic              stp_lft,
   input  logic              stp_rght,
   input  logic [HDNG_W-1:0] hdng,
   input  logic              clr,
   input  logic              take,
   output req_t              req
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req <= '0;
      end else if (clr) begin
         req <= '0;
      end else if (strt_hdng || strt_mv) begin
         // heading wins when both pulses coincide
         req <= {1'b1, strt_mv & ~strt_hdng, stp_lft, stp_rght, hdng};
      end else if (take) begin
         req.vld <= 1'b0;
      end
   end

endmodule

// File: rtl/nav_arb.sv
// Arbiter between command processor and maze solver for the single navigate
// unit: issues one move at a time, holds its controls, routes completion back.
module nav_arb
   import nav_arb_pkg::*;
#(
   parameter int TMO_W    = 26,
   parameter int FAST_SIM = 1
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_md,
   input  logic              strt_hdng_cmd,
   input  logic              strt_mv_cmd,
   input  logic              stp_lft_cmd,
   input  logic              stp_rght_cmd,
   input  logic [HDNG_W-1:0] dsrd_hdng_cmd,
   input  logic              strt_hdng_slv,
   input  logic              strt_mv_slv,
   input  logic              stp_lft_slv,
   input  logic              stp_rght_slv,
   input  logic [HDNG_W-1:0] dsrd_hdng_slv,
   input  logic              mv_cmplt,
   input  logic              sol_cmplt,
   output logic              strt_hdng,
   output logic              strt_mv,
   output logic              stp_lft,
   output logic              stp_rght,
   output logic [HDNG_W-1:0] dsrd_hdng,
   output logic              mv_cmplt_cmd,
   output logic              mv_cmplt_slv,
   output logic              busy,
   output logic              owner,
   output logic              tmo
);

   localparam int              WD_W    = (FAST_SIM != 0) ? 16 : TMO_W;
   localparam logic [WD_W-1:0] WD_MAX  = '1;
   localparam logic [WD_W-1:0] WD_LAST = WD_MAX - 1'b1;

   req_t            cmd_req;
   req_t            slv_req;
   req_t            sel;
   state_t          state;
   owner_t          own;
   logic [WD_W-1:0] wd_cnt;
   logic            take;
   logic            finish;
   logic            fin_tmo;

   // Only the requester selected by cmd_md is ever eligible.
   always_comb begin
      sel = slv_req;
      if (cmd_md) begin
         sel = cmd_req;
      end
   end

   assign take    = (state == IDLE) && sel.vld;
   assign finish  = ((state == ISSUE) && mv_cmplt) ||
                    ((state == WAIT) && (mv_cmplt || (wd_cnt == WD_LAST)));
   assign fin_tmo = finish && !mv_cmplt;
   assign owner   = own;

   nav_req_slot u_slot_cmd (
      .clk       (clk),
      .rst       (rst),
      .strt_hdng (strt_hdng_cmd),
      .strt_mv   (strt_mv_cmd),
      .stp_lft   (stp_lft_cmd),
      .stp_rght  (stp_rght_cmd),
      .hdng      (dsrd_hdng_cmd),
      .clr       (~cmd_md),
      .take      (take & cmd_md),
      .req       (cmd_req)
   );

   nav_req_slot u_slot_slv (
      .clk       (clk),
      .rst       (rst),
      .strt_hdng (strt_hdng_slv),
      .strt_mv   (strt_mv_slv),
      .stp_lft   (stp_lft_slv),
      .stp_rght  (stp_rght_slv),
      .hdng      (dsrd_hdng_slv),
      .clr       (cmd_md | sol_cmplt),
      .take      (take & ~cmd_md),
      .req       (slv_req)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         own          <= OWN_CMD;
         wd_cnt       <= '0;
         strt_hdng    <= 1'b0;
         strt_mv      <= 1'b0;
         stp_lft      <= 1'b0;
         stp_rght     <= 1'b0;
         dsrd_hdng    <= '0;
         mv_cmplt_cmd <= 1'b0;
         mv_cmplt_slv <= 1'b0;
         busy         <= 1'b0;
         tmo          <= 1'b0;
      end else begin
         strt_hdng    <= 1'b0;
         strt_mv      <= 1'b0;
         mv_cmplt_cmd <= 1'b0;
         mv_cmplt_slv <= 1'b0;
         tmo          <= 1'b0;
         case (state)
            IDLE: begin
               if (take) begin
                  state     <= ISSUE;
                  own       <= cmd_md ? OWN_CMD : OWN_SLV;
                  dsrd_hdng <= sel.hdng;
                  stp_lft   <= sel.stp_lft;
                  stp_rght  <= sel.stp_rght;
                  strt_hdng <= ~sel.is_mv;
                  strt_mv   <= sel.is_mv;
                  busy      <= 1'b1;
               end
            end
            ISSUE, WAIT: begin
               if (finish) begin
                  // completion goes to the latched owner, whatever cmd_md is now
                  state        <= DONE;
                  stp_lft      <= 1'b0;
                  stp_rght     <= 1'b0;
                  mv_cmplt_cmd <= (own == OWN_CMD);
                  mv_cmplt_slv <= (own == OWN_SLV);
                  tmo          <= fin_tmo;
                  if (fin_tmo) begin
                     wd_cnt <= WD_MAX;
                  end
               end else if (state == ISSUE) begin
                  state <= WAIT;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy   <= 1'b0;
               wd_cnt <= '0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nav_arb.sv
// Self-checking bench for nav_arb: directed scenarios plus random traffic,
// compared every cycle against a move-level behavioural model.
module tb_nav_arb;

   localparam int TMO_AGE = 65535;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_md = 1'b1;
   logic        strt_hdng_cmd = 1'b0, strt_mv_cmd = 1'b0, stp_lft_cmd = 1'b0, stp_rght_cmd = 1'b0;
   logic [11:0] dsrd_hdng_cmd = '0;
   logic        strt_hdng_slv = 1'b0, strt_mv_slv = 1'b0, stp_lft_slv = 1'b0, stp_rght_slv = 1'b0;
   logic [11:0] dsrd_hdng_slv = '0;
   logic        mv_cmplt = 1'b0, sol_cmplt = 1'b0;
   logic        strt_hdng, strt_mv, stp_lft, stp_rght;
   logic [11:0] dsrd_hdng;
   logic        mv_cmplt_cmd, mv_cmplt_slv, busy, owner, tmo;

   int n_cmp = 0;
   int n_bad = 0;
   int n_tmo_seen = 0;
   int n_strt_seen = 0;

   // model: pending requests per requester (0 = cmd, 1 = slv)
   bit          p_vld[2];
   bit          p_mv[2];
   bit          p_sl[2];
   bit          p_sr[2];
   logic [11:0] p_h[2];
   // model: the outstanding move
   bit          m_open, m_closing, m_tmo, m_mv, m_sl, m_sr, m_own;
   int          m_age;
   logic [11:0] m_h;

   nav_arb #(.TMO_W(26), .FAST_SIM(1)) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_md        (cmd_md),
      .strt_hdng_cmd (strt_hdng_cmd),
      .strt_mv_cmd   (strt_mv_cmd),
      .stp_lft_cmd   (stp_lft_cmd),
      .stp_rght_cmd  (stp_rght_cmd),
      .dsrd_hdng_cmd (dsrd_hdng_cmd),
      .strt_hdng_slv (strt_hdng_slv),
      .strt_mv_slv   (strt_mv_slv),
      .stp_lft_slv   (stp_lft_slv),
      .stp_rght_slv  (stp_rght_slv),
      .dsrd_hdng_slv (dsrd_hdng_slv),
      .mv_cmplt      (mv_cmplt),
      .sol_cmplt     (sol_cmplt),
      .strt_hdng     (strt_hdng),
      .strt_mv       (strt_mv),
      .stp_lft       (stp_lft),
      .stp_rght      (stp_rght),
      .dsrd_hdng     (dsrd_hdng),
      .mv_cmplt_cmd  (mv_cmplt_cmd),
      .mv_cmplt_slv  (mv_cmplt_slv),
      .busy          (busy),
      .owner         (owner),
      .tmo           (tmo)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int r = 0; r < 2; r++) begin
         p_vld[r] = 0; p_mv[r] = 0; p_sl[r] = 0; p_sr[r] = 0; p_h[r] = '0;
      end
      m_open = 0; m_closing = 0; m_tmo = 0; m_mv = 0; m_sl = 0; m_sr = 0;
      m_own = 0; m_age = 0; m_h = '0;
   endtask

   // Advance the model by one clock edge using the inputs present at the edge.
   task automatic model_edge();
      bit taken[2];
      bit clr, req, hh, mm;
      int r_el;
      taken[0] = 0;
      taken[1] = 0;
      if (rst) begin
         model_reset();
         return;
      end
      if (m_open) begin
         if (m_closing) begin
            m_open = 0; m_closing = 0; m_tmo = 0;
         end else if (mv_cmplt) begin
            m_closing = 1;
         end else if (m_age == TMO_AGE) begin
            m_closing = 1; m_tmo = 1;
         end
         m_age++;
         if (m_closing && !m_open) m_closing = 0;
         if (m_closing)
            $display("move done: owner=%0d hdng=%h is_mv=%0d timeout=%0d age=%0d",
                     m_own, m_h, m_mv, m_tmo, m_age);
      end else begin
         r_el = cmd_md ? 0 : 1;
         if (p_vld[r_el]) begin
            m_open = 1; m_closing = 0; m_tmo = 0; m_age = 0;
            m_own = r_el[0]; m_mv = p_mv[r_el]; m_sl = p_sl[r_el];
            m_sr = p_sr[r_el]; m_h = p_h[r_el];
            taken[r_el] = 1;
         end
      end
      for (int r = 0; r < 2; r++) begin
         clr = (r == 0) ? !cmd_md : (cmd_md || sol_cmplt);
         hh  = (r == 0) ? strt_hdng_cmd : strt_hdng_slv;
         mm  = (r == 0) ? strt_mv_cmd : strt_mv_slv;
         req = hh || mm;
         if (clr) begin
            p_vld[r] = 0;
         end else if (req) begin
            p_vld[r] = 1;
            p_mv[r]  = mm && !hh;
            p_sl[r]  = (r == 0) ? stp_lft_cmd : stp_lft_slv;
            p_sr[r]  = (r == 0) ? stp_rght_cmd : stp_rght_slv;
            p_h[r]   = (r == 0) ? dsrd_hdng_cmd : dsrd_hdng_slv;
         end else if (taken[r]) begin
            p_vld[r] = 0;
         end
      end
   endtask

   task automatic check(input string tag);
      logic [20:0] obs, exp;
      bit run;
      run = m_open && !m_closing;
      exp = {run && m_age == 0 && !m_mv, run && m_age == 0 && m_mv,
             run && m_sl, run && m_sr, m_h,
             m_closing && !m_own, m_closing && m_own,
             m_open, m_own, m_closing && m_tmo};
      obs = {strt_hdng, strt_mv, stp_lft, stp_rght, dsrd_hdng,
             mv_cmplt_cmd, mv_cmplt_slv, busy, owner, tmo};
      if (tmo === 1'b1) n_tmo_seen++;
      if (strt_hdng === 1'b1 || strt_mv === 1'b1) n_strt_seen++;
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s t=%0t observed=%h expected=%h (sh,sm,sl,sr,hdng,cc,cs,busy,own,tmo)",
                tag, $time, obs, exp);
      end
   endtask

   task automatic clear_pulses();
      strt_hdng_cmd = 0; strt_mv_cmd = 0; strt_hdng_slv = 0; strt_mv_slv = 0;
      mv_cmplt = 0; sol_cmplt = 0;
   endtask

   // One clock: inputs already driven; model steps at the edge, outputs checked 1 unit later.
   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1 check(tag);
      @(negedge clk);
      clear_pulses();
   endtask

   task automatic ticks(input int n, input string tag);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   initial begin
      int strt_before;
      model_reset();
      #1 check("reset_async");
      ticks(2, "reset_hold");
      rst = 0;

      // command heading move, then completion routed to cmd
      cmd_md = 1; dsrd_hdng_cmd = 12'h3FF; strt_hdng_cmd = 1;
      tick("cmd_req");
      ticks(3, "cmd_issue_wait");
      mv_cmplt = 1;
      tick("cmd_cmplt");
      ticks(4, "cmd_done");

      // solver move with stop-left, second request queued while busy
      cmd_md = 0; tick("md_switch");
      stp_lft_slv = 1; dsrd_hdng_slv = 12'h123; strt_mv_slv = 1;
      tick("slv_req");
      ticks(4, "slv_wait");
      stp_lft_slv = 0; dsrd_hdng_slv = 12'hC00; strt_mv_slv = 1;
      tick("slv_queue");
      ticks(3, "slv_wait2");
      mv_cmplt = 1; tick("slv_cmplt1");
      ticks(6, "slv_gap_issue");
      mv_cmplt = 1; tick("slv_cmplt2");
      ticks(4, "slv_idle");

      // queued solver request discarded by sol_cmplt
      dsrd_hdng_slv = 12'h0A5; strt_mv_slv = 1; tick("sol_req1");
      ticks(2, "sol_wait");
      dsrd_hdng_slv = 12'h05A; strt_mv_slv = 1; tick("sol_req2");
      sol_cmplt = 1; tick("sol_cmplt");
      strt_before = n_strt_seen;
      mv_cmplt = 1; tick("sol_mv_cmplt");
      ticks(8, "sol_after");
      n_cmp++;
      assert (n_strt_seen == strt_before) else begin
         n_bad++;
         $error("FAIL sol_no_reissue starts=%0d required=0", n_strt_seen - strt_before);
      end

      // watchdog: no completion at all
      dsrd_hdng_slv = 12'h800; strt_hdng_slv = 1; tick("tmo_req");
      ticks(TMO_AGE + 6, "tmo_run");
      n_cmp++;
      assert (n_tmo_seen == 1) else begin
         n_bad++;
         $error("FAIL tmo_count observed=%0d required=1", n_tmo_seen);
      end

      // mv_cmplt in the ISSUE cycle
      cmd_md = 1; dsrd_hdng_cmd = 12'h7FF; stp_rght_cmd = 1; strt_mv_cmd = 1;
      tick("early_req");
      mv_cmplt = 1; tick("early_issue");
      ticks(4, "early_done");
      stp_rght_cmd = 0;

      // asynchronous reset during WAIT, late completion ignored
      dsrd_hdng_cmd = 12'h456; strt_hdng_cmd = 1; tick("rst_req");
      ticks(4, "rst_wait");
      #2 rst = 1;
      #1 model_reset();
      check("rst_mid_move");
      @(negedge clk);
      tick("rst_hold");
      rst = 0;
      mv_cmplt = 1; tick("rst_late_cmplt");
      ticks(3, "rst_after");

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) cmd_md = ~cmd_md;
         strt_hdng_cmd = ($urandom_range(0, 9) == 0);
         strt_mv_cmd   = ($urandom_range(0, 9) == 0);
         strt_hdng_slv = ($urandom_range(0, 9) == 0);
         strt_mv_slv   = ($urandom_range(0, 9) == 0);
         stp_lft_cmd   = $urandom_range(0, 1) == 1;
         stp_rght_cmd  = $urandom_range(0, 1) == 1;
         stp_lft_slv   = $urandom_range(0, 1) == 1;
         stp_rght_slv  = $urandom_range(0, 1) == 1;
         dsrd_hdng_cmd = 12'($urandom);
         dsrd_hdng_slv = 12'($urandom);
         mv_cmplt      = ($urandom_range(0, 7) == 0);
         sol_cmplt     = ($urandom_range(0, 39) == 0);
         tick("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
